// File: rtl/etapa_id_ex_if.sv
`default_nettype none
// ============================================================================
//  Interface   : etapa_id_ex_if
//  Description : Signal bundle for the ID/EX pipeline stage. It carries the
//                ID-side instruction, the register-file read port, the
//                write-back bypass, the stall/flush controls and the
//                registered EX-side fields.
//  Revision    : 1.0 - initial release
// ============================================================================
interface etapa_id_ex_if;
    // ID side
    logic        valid_id;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    // Register-file read port
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    // Write-back port (shared with the register file)
    logic        wb_RegWrite;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_writeData;
    // Pipeline control
    logic        stall;
    logic        flush;
    // EX side
    logic        valid_ex;
    logic [31:0] pc_ex;
    logic [6:0]  opcode_ex;
    logic [2:0]  funct3_ex;
    logic        funct7b5_ex;
    logic [4:0]  rd_ex;
    logic [4:0]  rs1_ex;
    logic [4:0]  rs2_ex;
    logic [31:0] rs1_val_ex;
    logic [31:0] rs2_val_ex;
    logic [31:0] imm_ex;
    logic        load_use;

    // Upstream view: ID stage, register file, write-back and hazard unit
    modport master (
        output valid_id, instr_id, pc_id,
        output readData1, readData2,
        output wb_RegWrite, wb_writeReg, wb_writeData,
        output stall, flush,
        input  readReg1, readReg2,
        input  valid_ex, pc_ex, opcode_ex, funct3_ex, funct7b5_ex,
        input  rd_ex, rs1_ex, rs2_ex, rs1_val_ex, rs2_val_ex, imm_ex,
        input  load_use
    );

    // Stage view
    modport slave (
        input  valid_id, instr_id, pc_id,
        input  readData1, readData2,
        input  wb_RegWrite, wb_writeReg, wb_writeData,
        input  stall, flush,
        output readReg1, readReg2,
        output valid_ex, pc_ex, opcode_ex, funct3_ex, funct7b5_ex,
        output rd_ex, rs1_ex, rs2_ex, rs1_val_ex, rs2_val_ex, imm_ex,
        output load_use
    );
endinterface
`default_nettype wire

// File: rtl/etapa_id_ex.sv
`default_nettype none
// ============================================================================
//  Module      : etapa_id_ex
//  Description : RV32I ID/EX pipeline register. Addresses the register file
//                from the decoded instruction, selects operands (x0 forcing
//                and same-cycle write-back bypass), builds the sign-extended
//                immediate, registers everything for EX with flush/stall
//                handling and flags load-use hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module etapa_id_ex (
    input  logic               CLK,
    input  logic               RST,
    etapa_id_ex_if.slave       bus
);

    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // Decoded fields of the instruction in ID
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_imm;

    // EX-side registers
    logic        r_valid;
    logic [31:0] r_pc;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;
    logic [31:0] r_imm;

    // Refresh of held operands while stalled (x0 is never refreshed)
    logic w_refresh1;
    logic w_refresh2;

    assign w_instr  = bus.instr_id;
    assign w_opcode = w_instr[6:0];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_rd     = w_instr[11:7];

    assign bus.readReg1 = w_rs1;
    assign bus.readReg2 = w_rs2;

    // Operand select: x0 reads as zero; the register file commits at the
    // same posedge we capture, so a concurrent write-back must be bypassed.
    always_comb begin
        w_op1 = bus.readData1;
        if (w_rs1 == 5'd0) begin
            w_op1 = 32'd0;
        end else if (bus.wb_RegWrite && (bus.wb_writeReg == w_rs1)) begin
            w_op1 = bus.wb_writeData;
        end
    end

    // Same selection for the second source
    always_comb begin
        w_op2 = bus.readData2;
        if (w_rs2 == 5'd0) begin
            w_op2 = 32'd0;
        end else if (bus.wb_RegWrite && (bus.wb_writeReg == w_rs2)) begin
            w_op2 = bus.wb_writeData;
        end
    end

    // Immediate generation by instruction format; unknown opcodes give 0
    always_comb begin
        w_imm = 32'd0;
        case (w_opcode)
            c_OP_IMM, c_OP_LOAD, c_OP_JALR:
                w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            c_OP_STORE:
                w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            c_OP_BRANCH:
                w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                         w_instr[30:25], w_instr[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {w_instr[31:12], 12'd0};
            c_OP_JAL:
                w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                         w_instr[20], w_instr[30:21], 1'b0};
            default:
                w_imm = 32'd0;
        endcase
    end

    assign w_refresh1 = bus.wb_RegWrite && (bus.wb_writeReg != 5'd0) &&
                        (bus.wb_writeReg == r_rs1);
    assign w_refresh2 = bus.wb_RegWrite && (bus.wb_writeReg != 5'd0) &&
                        (bus.wb_writeReg == r_rs2);

    // Pipeline register: reset > flush (bubble, all zero) > stall (hold with
    // operand refresh) > load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rs1_val  <= 32'd0;
            r_rs2_val  <= 32'd0;
            r_imm      <= 32'd0;
        end else if (bus.flush) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_opcode   <= 7'd0;
            r_funct3   <= 3'd0;
            r_funct7b5 <= 1'b0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rs1_val  <= 32'd0;
            r_rs2_val  <= 32'd0;
            r_imm      <= 32'd0;
        end else if (bus.stall) begin
            if (w_refresh1) begin
                r_rs1_val <= bus.wb_writeData;
            end
            if (w_refresh2) begin
                r_rs2_val <= bus.wb_writeData;
            end
        end else begin
            r_valid    <= bus.valid_id;
            r_pc       <= bus.pc_id;
            r_opcode   <= w_opcode;
            r_funct3   <= w_instr[14:12];
            r_funct7b5 <= w_instr[30];
            r_rd       <= w_rd;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rs1_val  <= w_op1;
            r_rs2_val  <= w_op2;
            r_imm      <= w_imm;
        end
    end

    assign bus.valid_ex    = r_valid;
    assign bus.pc_ex       = r_pc;
    assign bus.opcode_ex   = r_opcode;
    assign bus.funct3_ex   = r_funct3;
    assign bus.funct7b5_ex = r_funct7b5;
    assign bus.rd_ex       = r_rd;
    assign bus.rs1_ex      = r_rs1;
    assign bus.rs2_ex      = r_rs2;
    assign bus.rs1_val_ex  = r_rs1_val;
    assign bus.rs2_val_ex  = r_rs2_val;
    assign bus.imm_ex      = r_imm;

    // A load in EX whose destination is read by the valid instruction in ID
    assign bus.load_use = r_valid && (r_opcode == c_OP_LOAD) && (r_rd != 5'd0) &&
                          bus.valid_id &&
                          ((r_rd == w_rs1) || (r_rd == w_rs2));

endmodule
`default_nettype wire

// File: tb/tb_etapa_id_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_etapa_id_ex
//  Description : Directed self-checking bench for the ID/EX pipeline stage,
//                with a small register-file model behind the read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_etapa_id_ex;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    logic [31:0] rf [32];

    etapa_id_ex_if bus ();

    etapa_id_ex dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register-file model: combinational read, write at posedge (x0 ignored)
    assign bus.readData1 = rf[bus.readReg1];
    assign bus.readData2 = rf[bus.readReg2];

    always @(posedge CLK) begin
        if (bus.wb_RegWrite && bus.wb_writeReg != 5'd0)
            rf[bus.wb_writeReg] <= bus.wb_writeData;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_wb();
        bus.wb_RegWrite  = 1'b0;
        bus.wb_writeReg  = 5'd0;
        bus.wb_writeData = 32'd0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        n_checks++;
        if (bus.valid_ex !== 1'b0 || bus.rd_ex !== 5'd0 || bus.imm_ex !== 32'd0 || bus.pc_ex !== 32'd0) begin
            $display("FAIL reset_hold: valid=%b rd=%0d imm=%h pc=%h, want all 0", bus.valid_ex, bus.rd_ex, bus.imm_ex, bus.pc_ex);
            n_errors++;
        end
        RST = 1'b0;
        bus.valid_id = 1'b1;
        bus.instr_id = 32'h00A00093;   // addi x1,x0,10
        bus.pc_id    = 32'h0000_0040;
        tick();
        n_checks++;
        if (bus.valid_ex !== 1'b1 || bus.rd_ex !== 5'd1 || bus.imm_ex !== 32'h0000000A || bus.pc_ex !== 32'h40) begin
            $display("FAIL first_load: valid=%b rd=%0d imm=%h pc=%h, want 1/1/0000000a/00000040", bus.valid_ex, bus.rd_ex, bus.imm_ex, bus.pc_ex);
            n_errors++;
        end
        // Asynchronous reset mid-cycle
        #2;
        RST = 1'b1;
        #1;
        n_checks++;
        if (bus.valid_ex !== 1'b0 || bus.rd_ex !== 5'd0 || bus.imm_ex !== 32'd0 || bus.pc_ex !== 32'd0 || bus.opcode_ex !== 7'd0) begin
            $display("FAIL async_reset: valid=%b rd=%0d imm=%h pc=%h op=%b, want all 0", bus.valid_ex, bus.rd_ex, bus.imm_ex, bus.pc_ex, bus.opcode_ex);
            n_errors++;
        end
        #1;
        RST = 1'b0;
        tick();
        n_checks++;
        if (bus.valid_ex !== 1'b1 || bus.rd_ex !== 5'd1 || bus.imm_ex !== 32'h0000000A || bus.rs1_val_ex !== 32'd0) begin
            $display("FAIL reload: valid=%b rd=%0d imm=%h rs1v=%h, want 1/1/0000000a/00000000", bus.valid_ex, bus.rd_ex, bus.imm_ex, bus.rs1_val_ex);
            n_errors++;
        end
    endtask

    task automatic test_plain_read();
        rf[5] = 32'h0000A234;
        rf[6] = 32'h00001234;
        bus.instr_id = 32'h006283B3;   // add x7,x5,x6
        bus.pc_id    = 32'h0000_0100;
        #1;
        n_checks++;
        if (bus.readReg1 !== 5'd5 || bus.readReg2 !== 5'd6) begin
            $display("FAIL read_addr: rr1=%0d rr2=%0d, want 5/6", bus.readReg1, bus.readReg2);
            n_errors++;
        end
        tick();
        n_checks++;
        if (bus.rs1_val_ex !== 32'h0000A234 || bus.rs2_val_ex !== 32'h00001234 || bus.rd_ex !== 5'd7 || bus.imm_ex !== 32'd0) begin
            $display("FAIL plain_read: rs1v=%h rs2v=%h rd=%0d imm=%h, want 0000a234/00001234/7/0", bus.rs1_val_ex, bus.rs2_val_ex, bus.rd_ex, bus.imm_ex);
            n_errors++;
        end
        n_checks++;
        if (bus.opcode_ex !== 7'b0110011 || bus.funct3_ex !== 3'd0 || bus.funct7b5_ex !== 1'b0 ||
            bus.rs1_ex !== 5'd5 || bus.rs2_ex !== 5'd6 || bus.pc_ex !== 32'h100) begin
            $display("FAIL plain_fields: op=%b f3=%0d f7b5=%b rs1=%0d rs2=%0d pc=%h", bus.opcode_ex, bus.funct3_ex, bus.funct7b5_ex, bus.rs1_ex, bus.rs2_ex, bus.pc_ex);
            n_errors++;
        end
    endtask

    task automatic test_bypass();
        bus.instr_id     = 32'h006283B3;
        bus.wb_RegWrite  = 1'b1;
        bus.wb_writeReg  = 5'd5;
        bus.wb_writeData = 32'hDEADBEEF;
        tick();
        idle_wb();
        n_checks++;
        if (bus.rs1_val_ex !== 32'hDEADBEEF || bus.rs2_val_ex !== 32'h00001234) begin
            $display("FAIL bypass: rs1v=%h rs2v=%h, want deadbeef/00001234", bus.rs1_val_ex, bus.rs2_val_ex);
            n_errors++;
        end
        // x0 read with junk on the read port and a write-back aimed at x0
        rf[0]            = 32'h55555555;
        bus.instr_id     = 32'h006003B3;   // add x7,x0,x6
        bus.wb_RegWrite  = 1'b1;
        bus.wb_writeReg  = 5'd0;
        bus.wb_writeData = 32'hCAFEF00D;
        tick();
        idle_wb();
        n_checks++;
        if (bus.rs1_val_ex !== 32'd0 || bus.rs2_val_ex !== 32'h00001234) begin
            $display("FAIL x0_read: rs1v=%h rs2v=%h, want 00000000/00001234", bus.rs1_val_ex, bus.rs2_val_ex);
            n_errors++;
        end
    endtask

    task automatic test_immediates();
        logic [31:0] instrs [5];
        logic [31:0] expect_imm [5];
        instrs[0] = 32'hFE20AE23; expect_imm[0] = 32'hFFFFFFFC;   // sw x2,-4(x1)
        instrs[1] = 32'hFE000CE3; expect_imm[1] = 32'hFFFFFFF8;   // beq -8
        instrs[2] = 32'h123452B7; expect_imm[2] = 32'h12345000;   // lui
        instrs[3] = 32'h001000EF; expect_imm[3] = 32'h00000800;   // jal +2048
        instrs[4] = 32'hFFFFFFFF; expect_imm[4] = 32'h00000000;   // unknown opcode
        for (int i = 0; i < 5; i++) begin
            bus.instr_id = instrs[i];
            tick();
            n_checks++;
            if (bus.imm_ex !== expect_imm[i]) begin
                $display("FAIL imm_%0d: instr=%h imm=%h, want %h", i, instrs[i], bus.imm_ex, expect_imm[i]);
                n_errors++;
            end
        end
    endtask

    task automatic test_stall_refresh_flush();
        rf[5] = 32'h0000A234;
        rf[6] = 32'h00001234;
        bus.valid_id = 1'b1;
        bus.instr_id = 32'h006283B3;
        bus.pc_id    = 32'h0000_0200;
        tick();
        bus.stall    = 1'b1;
        bus.valid_id = 1'b0;
        bus.instr_id = 32'h00A00093;
        bus.pc_id    = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.valid_ex !== 1'b1 || bus.rd_ex !== 5'd7 || bus.pc_ex !== 32'h200 ||
                bus.rs1_val_ex !== 32'h0000A234 || bus.imm_ex !== 32'd0) begin
                $display("FAIL stall_hold_%0d: valid=%b rd=%0d pc=%h rs1v=%h imm=%h", i, bus.valid_ex, bus.rd_ex, bus.pc_ex, bus.rs1_val_ex, bus.imm_ex);
                n_errors++;
            end
        end
        bus.wb_RegWrite  = 1'b1;
        bus.wb_writeReg  = 5'd5;
        bus.wb_writeData = 32'h00000011;
        tick();
        idle_wb();
        n_checks++;
        if (bus.rs1_val_ex !== 32'h00000011 || bus.rs2_val_ex !== 32'h00001234 || bus.rd_ex !== 5'd7) begin
            $display("FAIL refresh: rs1v=%h rs2v=%h rd=%0d, want 00000011/00001234/7", bus.rs1_val_ex, bus.rs2_val_ex, bus.rd_ex);
            n_errors++;
        end
        bus.flush = 1'b1;
        tick();
        n_checks++;
        if (bus.valid_ex !== 1'b0 || bus.rd_ex !== 5'd0 || bus.rs1_val_ex !== 32'd0 || bus.pc_ex !== 32'd0) begin
            $display("FAIL flush: valid=%b rd=%0d rs1v=%h pc=%h, want all 0", bus.valid_ex, bus.rd_ex, bus.rs1_val_ex, bus.pc_ex);
            n_errors++;
        end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_load_use();
        bus.valid_id = 1'b1;
        bus.instr_id = 32'h0000A183;   // lw x3,0(x1)
        tick();
        n_checks++;
        if (bus.opcode_ex !== 7'b0000011 || bus.rd_ex !== 5'd3 || bus.funct3_ex !== 3'd2 || bus.rs1_ex !== 5'd1) begin
            $display("FAIL lw_fields: op=%b rd=%0d f3=%0d rs1=%0d", bus.opcode_ex, bus.rd_ex, bus.funct3_ex, bus.rs1_ex);
            n_errors++;
        end
        bus.instr_id = 32'h00218233;   // add x4,x3,x2
        #1;
        n_checks++;
        if (bus.load_use !== 1'b1) begin
            $display("FAIL load_use_rs1: got %b, want 1", bus.load_use);
            n_errors++;
        end
        bus.instr_id = 32'h00310233;   // add x4,x2,x3
        #1;
        n_checks++;
        if (bus.load_use !== 1'b1) begin
            $display("FAIL load_use_rs2: got %b, want 1", bus.load_use);
            n_errors++;
        end
        bus.valid_id = 1'b0;
        #1;
        n_checks++;
        if (bus.load_use !== 1'b0) begin
            $display("FAIL load_use_id_bubble: got %b, want 0", bus.load_use);
            n_errors++;
        end
        // Load into x0 followed by an instruction reading x0
        bus.valid_id = 1'b1;
        bus.instr_id = 32'h0000A003;   // lw x0,0(x1)
        tick();
        bus.instr_id = 32'h00200233;   // add x4,x0,x2
        #1;
        n_checks++;
        if (bus.load_use !== 1'b0) begin
            $display("FAIL load_use_rd0: got %b, want 0", bus.load_use);
            n_errors++;
        end
        // Load that is itself a bubble
        bus.valid_id = 1'b0;
        bus.instr_id = 32'h0000A183;
        tick();
        bus.valid_id = 1'b1;
        bus.instr_id = 32'h00218233;
        #1;
        n_checks++;
        if (bus.load_use !== 1'b0) begin
            $display("FAIL load_use_ex_bubble: got %b, want 0", bus.load_use);
            n_errors++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        RST          = 1'b1;
        bus.valid_id = 1'b0;
        bus.instr_id = 32'd0;
        bus.pc_id    = 32'd0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        idle_wb();
        test_reset();
        test_plain_read();
        test_bypass();
        test_immediates();
        test_stall_refresh_flush();
        test_load_use();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
